// File: rtl/pwr_iso_ctrl.sv
// pwr_iso_ctrl
// Power/isolation sequencer for one switchable power domain. It drives the
// active-low isolation enable (Ib pins of the IsoAND_TL_1P clamps), the power
// switch enable and the retention save/restore strobes. It guarantees that
// the domain is isolated before power is removed and is un-isolated only
// after the rail is good and retention state has been restored.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pd_req       power-down request (level, honoured only in ON)
//   pu_req       power-up request (level, honoured only in OFF)
//   pwr_ack      rail-good status from the power switch (pre-synchronised)
//   iso          active-low isolation enable, 0 = domain outputs clamped low
//   pwr_en       power switch enable, 1 = rail on
//   ret_save     one-cycle retention save strobe
//   ret_restore  one-cycle retention restore strobe
//   busy         high in every state except ON and OFF
//   is_off       high only in OFF
//   err          sticky power-ack timeout flag, cleared only by reset
//
// All outputs come straight from flops: they are decoded from the next state
// and registered, so they change on the same edge as the state register.

module pwr_iso_ctrl #(
  parameter int ISO_SETUP   = 2,
  parameter int ISO_HOLD    = 3,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pd_req,
  input  logic pu_req,
  input  logic pwr_ack,
  output logic iso,
  output logic pwr_en,
  output logic ret_save,
  output logic ret_restore,
  output logic busy,
  output logic is_off,
  output logic err
);

  typedef enum logic [2:0] {
    S_ON,
    S_ISO_SET,
    S_SAVE,
    S_DN_WAIT,
    S_OFF,
    S_UP_WAIT,
    S_RESTORE,
    S_ISO_REL
  } state_t;

  // The counter is cleared on state entry, so a state that must last N
  // cycles exits when the counter shows N-1. A zero setup/hold still
  // occupies the state for one cycle.
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'((ISO_SETUP > 0) ? ISO_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'((ISO_HOLD  > 0) ? ISO_HOLD  - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic             iso_d, pwr_en_d, ret_save_d, ret_restore_d, busy_d, is_off_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_UP_WAIT;
      cnt         <= '0;
      err         <= 1'b0;
      iso         <= 1'b0;
      pwr_en      <= 1'b1;
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      busy        <= 1'b1;
      is_off      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      err         <= err_nxt;
      iso         <= iso_d;
      pwr_en      <= pwr_en_d;
      ret_save    <= ret_save_d;
      ret_restore <= ret_restore_d;
      busy        <= busy_d;
      is_off      <= is_off_d;
    end
  end

  // A missing ack in DN_WAIT still ends in OFF (rail assumed off, isolation
  // kept); a missing ack in UP_WAIT also falls back to OFF so software can
  // retry, and err records either event.
  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    case (state)
      S_ON:      if (pd_req) state_nxt = S_ISO_SET;
      S_ISO_SET: if (cnt == SETUP_LAST) state_nxt = S_SAVE;
      S_SAVE:    state_nxt = S_DN_WAIT;
      S_DN_WAIT: begin
        if (!pwr_ack) begin
          state_nxt = S_OFF;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = S_OFF;
          err_nxt   = 1'b1;
        end
      end
      S_OFF:     if (pu_req) state_nxt = S_UP_WAIT;
      S_UP_WAIT: begin
        if (pwr_ack) begin
          state_nxt = S_RESTORE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = S_OFF;
          err_nxt   = 1'b1;
        end
      end
      S_RESTORE: state_nxt = S_ISO_REL;
      S_ISO_REL: if (cnt == HOLD_LAST) state_nxt = S_ON;
      default:   state_nxt = S_UP_WAIT;
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_MAX) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Output decode of the upcoming state. In OFF the switch enable follows
  // err, so after a failed power-up the rail request stays asserted.
  always_comb begin
    iso_d         = 1'b0;
    pwr_en_d      = 1'b1;
    ret_save_d    = 1'b0;
    ret_restore_d = 1'b0;
    busy_d        = 1'b1;
    is_off_d      = 1'b0;
    case (state_nxt)
      S_ON: begin
        iso_d  = 1'b1;
        busy_d = 1'b0;
      end
      S_SAVE:    ret_save_d = 1'b1;
      S_DN_WAIT: pwr_en_d   = 1'b0;
      S_OFF: begin
        pwr_en_d = err_nxt;
        busy_d   = 1'b0;
        is_off_d = 1'b1;
      end
      S_RESTORE: ret_restore_d = 1'b1;
      default: ;
    endcase
  end

endmodule
